// File: rtl/riscv_uart_pkg.sv
// Shared definitions for the RISC-V UART transmit path: serializer state
// encodings and default sizing.
package riscv_uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DEFAULT_FIFO_DEPTH   = 16;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data is presented
// combinationally at the read pointer so a pop consumes it in the same cycle.
module riscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        count    = wr_ptr_q - rd_ptr_q;
        // A pop in this cycle never frees room for a push in the same cycle.
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_uart_tx.sv
// 8N1 UART transmitter fed by the core's byte stream through a small FIFO;
// the FIFO full flag is returned to the core as back-pressure.
module riscv_uart_tx
    import riscv_uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = UART_DEFAULT_FIFO_DEPTH,
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                          i_riscv_uart_clk,
    input  logic                          i_riscv_uart_rst,
    input  logic [7:0]                    i_riscv_uart_tx_data,
    input  logic                          i_riscv_uart_tx_valid,
    output logic                          o_riscv_uart_fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_riscv_uart_fifo_count,
    output logic                          o_riscv_uart_busy,
    output logic                          o_riscv_uart_tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          baud_last;

    logic          fifo_pop;
    logic [7:0]    fifo_rd_data;
    logic          fifo_empty;

    riscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_riscv_uart_clk),
        .rst       (i_riscv_uart_rst),
        .push      (i_riscv_uart_tx_valid),
        .push_data (i_riscv_uart_tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (o_riscv_uart_fifo_full),
        .empty     (fifo_empty),
        .count     (o_riscv_uart_fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        fifo_pop  = 1'b0;
        baud_last = (baud_q == BAUD_LAST);

        case (state_q)
            UART_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    bit_d    = 3'd0;
                    baud_d   = '0;
                    state_d  = UART_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            UART_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = UART_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // The line is registered, so present the next bit now.
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        bit_d    = 3'd0;
                        state_d  = UART_START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = UART_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = UART_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_riscv_uart_clk or posedge i_riscv_uart_rst) begin
        if (i_riscv_uart_rst) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign o_riscv_uart_busy = busy_q;
    assign o_riscv_uart_tx   = tx_q;

endmodule
